// File: rtl/max_pool_2x2.sv
// Streaming 2x2 / stride-2 max pool over a raster-order signed feature map.
// Define MAXPOOL_RELU_EN to fuse a ReLU into the output-register load.
module max_pool_2x2 #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic signed [DATA_W-1:0] in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [DATA_W-1:0] out_data_o,
    output logic                     done_o
);
    localparam int HALF = IMG_W / 2;
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0]            col_q, col_d;
    logic [RW-1:0]            row_q, row_d;
    logic signed [DATA_W-1:0] hold_q;
    logic signed [DATA_W-1:0] linebuf_q [HALF];
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     last_q, last_d;
    logic                     done_q, done_d;

    logic                     in_acc, out_acc, load;
    logic [LW-1:0]            lb_idx;
    logic signed [DATA_W-1:0] hmax, pool, pooled;

    assign in_ready_o  = !out_valid_q || out_ready_i;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign done_o      = done_q;

    assign in_acc  = in_valid_i && in_ready_o;
    assign out_acc = out_valid_q && out_ready_i;
    assign lb_idx  = LW'(col_q >> 1);
    assign load    = in_acc && row_q[0] && col_q[0];

    always_comb begin
        hmax = (in_data_i > hold_q) ? in_data_i : hold_q;
        pool = (linebuf_q[lb_idx] > hmax) ? linebuf_q[lb_idx] : hmax;
`ifdef MAXPOOL_RELU_EN
        pooled = pool[DATA_W-1] ? '0 : pool;
`else
        pooled = pool;
`endif
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_acc) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // A load on the same cycle as an accept wins; the frame-end flag follows the held value.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        last_d      = last_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = pooled;
            last_d      = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
        end else if (out_acc) begin
            out_valid_d = 1'b0;
            last_d      = 1'b0;
        end
        done_d = out_acc && last_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            last_q      <= last_d;
            done_q      <= done_d;
            if (in_acc && !col_q[0])
                hold_q <= in_data_i;
        end
    end

    // Every entry is rewritten on an even row before the odd row reads it, so no reset.
    always_ff @(posedge clk_i) begin
        if (in_acc && !row_q[0] && col_q[0])
            linebuf_q[lb_idx] <= hmax;
    end
endmodule

// File: tb/tb_max_pool_2x2.sv
// Bench for max_pool_2x2 on a 4x4 map: directed and random frames vs a window-max model.
module tb_max_pool_2x2;
    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    typedef logic signed [15:0] frame_t [N];
    typedef struct {
        logic signed [15:0] v;
        bit                 last;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] out_data;
    logic               done;

    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    bit   exp_done = 1'b0;
    exp_t expq[$];

    max_pool_2x2 #(.DATA_W(16), .IMG_W(W), .IMG_H(H)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .done_o(done)
    );

    always #5 clk = ~clk;

    // Reference: each output is the max of a 2x2 window of the stored frame.
    task automatic model_frame(input frame_t px);
        logic signed [15:0] m;
        for (int r = 0; r < H / 2; r++)
            for (int c = 0; c < W / 2; c++) begin
                m = px[(2 * r) * W + 2 * c];
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (px[(2 * r + dr) * W + 2 * c + dc] > m)
                            m = px[(2 * r + dr) * W + 2 * c + dc];
`ifdef MAXPOOL_RELU_EN
                if (m < 0) m = '0;
`endif
                expq.push_back('{m, (r == H / 2 - 1) && (c == W / 2 - 1)});
            end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_done = 1'b0;
        end else begin
            tests++;
            assert (done === exp_done) else begin
                fails++;
                $error("FAIL done got=%0b exp=%0b", done, exp_done);
            end
            if (done === 1'b1) done_cnt++;
            exp_done = 1'b0;
            if (out_valid && out_ready) begin
                tests++;
                assert (expq.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_out got=%0d exp=none", out_data);
                end
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    tests++;
                    assert (out_data === e.v) else begin
                        fails++;
                        $error("FAIL out_data got=%0d exp=%0d", out_data, e.v);
                    end
                    exp_done = e.last;
                end
            end
        end
    end

    task automatic drive_pixels(input frame_t px, input int lo, input int hi,
                                input int vp, input int rp);
        int i;
        int cyc;
        bit acc;
        i = lo;
        cyc = 0;
        while (i < hi && cyc < 2000) begin
            in_valid  = ($urandom_range(99) < vp);
            in_data   = px[i];
            out_ready = ($urandom_range(99) < rp);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        in_valid = 1'b0;
        tests++;
        assert (i == hi) else begin
            fails++;
            $error("FAIL input_timeout got=%0d exp=%0d", i, hi);
        end
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (expq.size() != 0 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        assert (expq.size() == 0) else begin
            fails++;
            $error("FAIL drain_timeout got=%0d exp=0", expq.size());
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        expq.delete();
        repeat (2) begin
            @(negedge clk);
            tests++;
            assert ({out_valid, out_data, done, in_ready} === {1'b0, 16'sd0, 1'b0, 1'b1}) else begin
                fails++;
                $error("FAIL reset_state got=%b/%0d/%b/%b exp=0/0/0/1",
                       out_valid, out_data, done, in_ready);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        frame_t ramp, fr;

        for (int i = 0; i < N; i++) ramp[i] = 16'(i);
        do_reset();

        // Ramp at full rate: 5, 7, 13, 15 with one done
        model_frame(ramp);
        drive_pixels(ramp, 0, N, 100, 100);
        drain();

        // Backpressure: hold 5 pending for 5 cycles
        model_frame(ramp);
        drive_pixels(ramp, 0, 6, 100, 100);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = ramp[6];
        repeat (5) begin
            @(negedge clk);
            tests++;
            assert ({in_ready, out_valid, out_data} === {1'b0, 1'b1, 16'sd5}) else begin
                fails++;
                $error("FAIL stall got=%b/%b/%0d exp=0/1/5", in_ready, out_valid, out_data);
            end
            @(posedge clk); #1;
        end
        drive_pixels(ramp, 6, N, 100, 100);
        drain();

        // Negative window {-3,-8,-1,-5} in the top-left position
        for (int i = 0; i < N; i++) fr[i] = 16'($urandom);
        fr[0] = -16'sd3; fr[1] = -16'sd8; fr[W] = -16'sd1; fr[W + 1] = -16'sd5;
        model_frame(fr);
        drive_pixels(fr, 0, N, 100, 100);
        drain();

        // Signed extremes: near -32768 and near +32767
        for (int i = 0; i < N; i++) fr[i] = (i < N / 2) ? 16'(-32768 + i) : 16'(32767 - i);
        model_frame(fr);
        drive_pixels(fr, 0, N, 100, 100);
        drain();

        // Two back-to-back random frames with in_valid gaps and random out_ready
        for (int i = 0; i < N; i++) fr[i] = 16'($urandom);
        model_frame(fr);
        drive_pixels(fr, 0, N, 70, 60);
        for (int i = 0; i < N; i++) fr[i] = 16'($urandom);
        model_frame(fr);
        drive_pixels(fr, 0, N, 70, 60);
        drain();

        // Reset mid-frame with 5 pending, then replay the ramp
        drive_pixels(ramp, 0, 6, 100, 0);
        do_reset();
        model_frame(ramp);
        drive_pixels(ramp, 0, N, 100, 100);
        drain();

        tests++;
        assert (done_cnt == 7) else begin
            fails++;
            $error("FAIL done_count got=%0d exp=7", done_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
